// File: rtl/bit_stream_packer.sv
// Packs a 1-bit/cycle valid/ready stream into WIDTH-bit words, with flush of partial words.
// Optional out_parity port when PACKER_PARITY_EN is defined.
module bit_stream_packer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_bit,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH):0]   out_len,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef PACKER_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int LW = CW + 1;

    localparam logic [0:0]    ST_ACC        = 1'b0;
    localparam logic [0:0]    ST_FLUSH_WAIT = 1'b1;
    localparam logic [CW-1:0] CNT_LAST      = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};
    localparam logic [LW-1:0] LEN_FULL      = LW'(WIDTH);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [LW-1:0]    out_len_q, out_len_d;
    logic             out_valid_q, out_valid_d;

    logic             slot_free_s;
    logic             accept_s;
    logic [CW-1:0]    pos_s;
    logic [CW-1:0]    cnt_s;
    logic [WIDTH-1:0] acc_s;
    logic             load_s;
    logic [LW-1:0]    load_len_s;

`ifdef PACKER_PARITY_EN
    logic par_q, par_d;

    function automatic logic word_parity(input logic [WIDTH-1:0] w);
        // Pad bits are always zero, so the whole-word XOR equals the valid-bit XOR.
        return ^w;
    endfunction
`endif

    // Handshake, accumulator update and output-load decision.
    always_comb begin
        slot_free_s = !out_valid_q || out_ready;
        in_ready    = !reset && (state_q == ST_ACC) && ((cnt_q != CNT_LAST) || slot_free_s);
        accept_s    = in_valid && in_ready;
        if (MSB_FIRST != 0) begin
            pos_s = CNT_LAST - cnt_q;
        end else begin
            pos_s = cnt_q;
        end
        acc_s = acc_q;
        if (accept_s) begin
            acc_s[pos_s] = in_bit;
            cnt_s        = cnt_q + CNT_ONE;
        end else begin
            cnt_s = cnt_q;
        end

        state_d     = state_q;
        cnt_d       = cnt_s;
        acc_d       = acc_s;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q && !out_ready;
        load_s      = 1'b0;
        load_len_s  = {1'b0, cnt_s};

        case (state_q)
            ST_ACC: begin
                if (accept_s && (cnt_q == CNT_LAST)) begin
                    load_s     = 1'b1;
                    load_len_s = LEN_FULL;
                end else if (flush && (cnt_s != CNT_ZERO)) begin
                    if (slot_free_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = ST_FLUSH_WAIT;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_FLUSH_WAIT: begin
                // Accumulator is frozen here; flush pulses are ignored.
                if (slot_free_s) begin
                    load_s  = 1'b1;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        if (load_s) begin
            out_data_d  = acc_s;
            out_len_d   = load_len_s;
            out_valid_d = 1'b1;
            cnt_d       = CNT_ZERO;
            acc_d       = {WIDTH{1'b0}};
        end else begin
            out_data_d = out_data_q;
        end
    end

`ifdef PACKER_PARITY_EN
    // Parity is computed on the word being loaded so it registers alongside out_data.
    always_comb begin
        if (load_s) begin
            par_d = word_parity(acc_s);
        end else begin
            par_d = par_q;
        end
    end
`endif

    // State, accumulator and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_ACC;
            cnt_q       <= CNT_ZERO;
            acc_q       <= {WIDTH{1'b0}};
            out_data_q  <= {WIDTH{1'b0}};
            out_len_q   <= {LW{1'b0}};
            out_valid_q <= 1'b0;
`ifdef PACKER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
`ifdef PACKER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;
`ifdef PACKER_PARITY_EN
    assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer: LSB-first and MSB-first instances share stimulus,
// and a scoreboard queue per instance holds the words each one must deliver.
module tb_bit_stream_packer;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] len;
    } word_t;

    logic       clock = 1'b0;
    logic       reset, in_bit, in_valid, flush, out_ready;
    logic       in_ready_l, in_ready_m, out_valid_l, out_valid_m;
    logic [7:0] out_data_l, out_data_m;
    logic [3:0] out_len_l, out_len_m;
`ifdef PACKER_PARITY_EN
    logic       par_l, par_m;
`endif

    int    n_cmp = 0;
    int    n_err = 0;
    word_t q_l[$];
    word_t q_m[$];
    word_t e_l, e_m;

    always #5 clock = ~clock;

    bit_stream_packer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clock(clock), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_l), .flush(flush), .out_data(out_data_l), .out_len(out_len_l),
        .out_valid(out_valid_l), .out_ready(out_ready)
`ifdef PACKER_PARITY_EN
        , .out_parity(par_l)
`endif
    );

    bit_stream_packer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clock(clock), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_m), .flush(flush), .out_data(out_data_m), .out_len(out_len_m),
        .out_valid(out_valid_m), .out_ready(out_ready)
`ifdef PACKER_PARITY_EN
        , .out_parity(par_m)
`endif
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bits are given first-received in bit 0; the MSB-first instance sees them mirrored.
    task automatic push_exp(input logic [7:0] d, input logic [3:0] len);
        q_l.push_back('{data: d, len: len});
        q_m.push_back('{data: rev8(d), len: len});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int waited = 0;
        in_bit   = b;
        in_valid = 1'b1;
        @(negedge clock);
        while (in_ready_l !== 1'b1 && waited < 50) begin
            waited++;
            @(negedge clock);
        end
        if (waited >= 50) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout observed=in_ready_low expected=accept");
        end
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    // Scoreboard: every transfer seen on either output must match the head of its queue.
    always @(negedge clock) begin
        if (!reset && out_valid_l && out_ready) begin
            if (q_l.size() == 0) begin
                check("sb_lsb_unexpected_word", {24'd0, out_data_l}, 32'hFFFF_FFFF);
            end else begin
                e_l = q_l.pop_front();
                check("sb_lsb_data", out_data_l, e_l.data);
                check("sb_lsb_len", out_len_l, e_l.len);
`ifdef PACKER_PARITY_EN
                check("sb_lsb_parity", par_l, ^e_l.data);
`endif
            end
        end
        if (!reset && out_valid_m && out_ready) begin
            if (q_m.size() == 0) begin
                check("sb_msb_unexpected_word", {24'd0, out_data_m}, 32'hFFFF_FFFF);
            end else begin
                e_m = q_m.pop_front();
                check("sb_msb_data", out_data_m, e_m.data);
                check("sb_msb_len", out_len_m, e_m.len);
`ifdef PACKER_PARITY_EN
                check("sb_msb_parity", par_m, ^e_m.data);
`endif
            end
        end
    end

    initial begin
        logic [7:0] w;
        reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check("rst_out_valid", out_valid_l, 1'b0);
        check("rst_out_len", out_len_l, 4'd0);
        check("rst_out_data", out_data_l, 8'h00);
        check("rst_in_ready", in_ready_l, 1'b0);
        tick();
        reset = 1'b0;

        // Full word 1,0,1,1,0,0,1,0
        out_ready = 1'b1;
        push_exp(8'h4D, 4'd8);
        send_word(8'h4D, 8);
        @(negedge clock);
        check("full_valid_latency", out_valid_l, 1'b1);
        check("full_lsb_data", out_data_l, 8'h4D);
        check("full_msb_data", out_data_m, 8'hB2);
        check("full_len", out_len_l, 4'd8);
        tick();

        // Backpressure: 16 bits with the consumer stalled
        out_ready = 1'b0;
        push_exp(8'hA5, 4'd8);
        push_exp(8'h3C, 4'd8);
        send_word(8'hA5, 8);
        send_word(8'h3C, 7);
        w = 8'h3C;
        in_bit   = w[7];
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("bp_in_ready_low", in_ready_l, 1'b0);
            check("bp_held_data", out_data_l, 8'hA5);
            check("bp_held_valid", out_valid_l, 1'b1);
        end
        tick();
        out_ready = 1'b1;
        send_bit(w[7]);
        @(negedge clock);
        check("bp_second_word", out_data_l, 8'h3C);
        tick();

        // Partial flush with the 4th bit in the same cycle
        push_exp(8'h07, 4'd4);
        send_word(8'h07, 3);
        flush = 1'b1;
        send_bit(1'b0);
        @(negedge clock);
        check("flush_lsb_data", out_data_l, 8'h07);
        check("flush_msb_data", out_data_m, 8'hE0);
        check("flush_len", out_len_l, 4'd4);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("flush_empty_ignored", out_valid_l, 1'b0);
        end
        tick();

        // Flush on the bit that completes a full word yields only the full word
        push_exp(8'hFF, 4'd8);
        send_word(8'hFF, 7);
        flush = 1'b1;
        send_bit(1'b1);
        @(negedge clock);
        check("flush_full_len", out_len_l, 4'd8);
        tick();
        repeat (2) begin
            @(negedge clock);
            check("flush_full_no_extra", out_valid_l, 1'b0);
        end
        tick();

        // FLUSH_WAIT: pending word stalled, partial flushed behind it
        out_ready = 1'b0;
        push_exp(8'h81, 4'd8);
        send_word(8'h81, 8);
        push_exp(8'h05, 4'd3);
        send_word(8'h05, 3);
        @(negedge clock);
        check("fw_ready_before_flush", in_ready_l, 1'b1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clock);
        check("fw_in_ready_low", in_ready_l, 1'b0);
        check("fw_old_word_held", out_data_l, 8'h81);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clock);
        check("fw_still_waiting", in_ready_m, 1'b0);
        tick();
        out_ready = 1'b1;
        @(negedge clock);
        check("fw_ready_low_on_release", in_ready_l, 1'b0);
        tick();
        @(negedge clock);
        check("fw_partial_valid", out_valid_l, 1'b1);
        check("fw_partial_len", out_len_l, 4'd3);
        check("fw_in_ready_after", in_ready_l, 1'b1);
        tick();

        // Reset mid-stream with a pending word and held bits
        out_ready = 1'b0;
        send_word(8'hC3, 8);
        send_word(8'h03, 2);
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("midrst_out_valid", out_valid_l, 1'b0);
        check("midrst_out_len", out_len_m, 4'd0);
        check("midrst_in_ready", in_ready_l, 1'b0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        push_exp(8'h5A, 4'd8);
        send_word(8'h5A, 8);
        @(negedge clock);
        check("postrst_word", out_data_l, 8'h5A);
        tick();

        repeat (4) tick();
        check("sb_lsb_drained", q_l.size(), 32'd0);
        check("sb_msb_drained", q_m.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
